// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and encodings for the memory-stage load/store unit.
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_t;

   localparam logic [2:0] MW_SB = 3'b001;
   localparam logic [2:0] MW_SH = 3'b010;
   localparam logic [2:0] MW_SW = 3'b100;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   localparam logic [1:0] RES_LOAD = 2'b01;

   function automatic logic is_store_code(input logic [2:0] mw);
      return (mw == MW_SB) || (mw == MW_SH) || (mw == MW_SW);
   endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface mem_stage_lsu_if;

   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_ready_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
      input  dmem_ready_i, dmem_rvalid_i, dmem_rdata_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
      output dmem_ready_i, dmem_rvalid_i, dmem_rdata_i
   );

endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Picks the addressed byte/half out of a load word and sign- or zero-extends it.
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_lane [4];
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = rdata_i[8*gi +: 8];
   end

   assign sel_byte = byte_lane[off_i];
   assign sel_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   always_comb begin
      case (funct3_i)
         LD_LB:   data_o = {{24{sel_byte[7]}}, sel_byte};
         LD_LH:   data_o = {{16{sel_half[15]}}, sel_half};
         LD_LBU:  data_o = {24'h0, sel_byte};
         LD_LHU:  data_o = {16'h0, sel_half};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: drives the data-memory bus, stalls the pipe while an access
// is outstanding, and holds the M/W pipeline register.
module mem_stage_lsu
   import mem_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            RegWriteM_i,
   input  logic [1:0]      ResultSrcM_i,
   input  logic [2:0]      MemWriteM_i,
   input  logic [2:0]      LoadFunct3M_i,
   input  logic [31:0]     ALUResultM_i,
   input  logic [31:0]     WriteDataM_i,
   input  logic [4:0]      RdM_i,
   input  logic [31:0]     PCPlus4M_i,
   mem_stage_lsu_if.master dmem,
   output logic            StallM_o,
   output logic            misaligned_o,
   output logic            RegWriteW_o,
   output logic [1:0]      ResultSrcW_o,
   output logic [31:0]     ALUResultW_o,
   output logic [31:0]     ReadDataW_o,
   output logic [4:0]      RdW_o,
   output logic [31:0]     PCPlus4W_o
);

   lsu_state_t  state_q, state_d;
   logic [1:0]  off;
   logic        is_store, is_load, mem_op, mis_access, aligned_op, mis_flag;
   logic        req, busy, complete;
   logic [3:0]  be;
   logic [31:0] load_data;

   logic        regwrite_w_q, regwrite_w_d;
   logic [1:0]  resultsrc_w_q, resultsrc_w_d;
   logic [31:0] alu_w_q, alu_w_d;
   logic [31:0] rdata_w_q, rdata_w_d;
   logic [4:0]  rd_w_q, rd_w_d;
   logic [31:0] pc4_w_q, pc4_w_d;

   assign off      = ALUResultM_i[1:0];
   assign is_store = is_store_code(MemWriteM_i);
   // A store code wins over a load ResultSrc when both are present.
   assign is_load  = (ResultSrcM_i == RES_LOAD) && !is_store;
   assign mem_op   = is_load || is_store;

   always_comb begin
      mis_access = 1'b0;
      if (is_store) begin
         mis_access = ((MemWriteM_i == MW_SH) && off[0]) ||
                      ((MemWriteM_i == MW_SW) && (off != 2'b00));
      end else if (is_load) begin
         mis_access = (((LoadFunct3M_i == LD_LH) || (LoadFunct3M_i == LD_LHU)) && off[0]) ||
                      ((LoadFunct3M_i == LD_LW) && (off != 2'b00));
      end
   end

   assign aligned_op = mem_op && !mis_access;
   assign mis_flag   = (state_q == ST_IDLE) && mem_op && mis_access;

   always_comb begin
      state_d  = state_q;
      req      = 1'b0;
      busy     = 1'b0;
      complete = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (aligned_op) begin
               req  = 1'b1;
               busy = 1'b1;
               if (!dmem.dmem_ready_i) begin
                  state_d = ST_REQ;
               end else if (is_store) begin
                  complete = 1'b1;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_REQ: begin
            req  = 1'b1;
            busy = 1'b1;
            if (dmem.dmem_ready_i) begin
               if (is_store) begin
                  complete = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            busy = 1'b1;
            if (dmem.dmem_rvalid_i) begin
               complete = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      be = 4'b1111;
      if (is_store) begin
         case (MemWriteM_i)
            MW_SB:   be = 4'b0001 << off;
            MW_SH:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
         endcase
      end
   end

   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_lane
      assign dmem.dmem_wdata_o[8*gi +: 8] =
         (MemWriteM_i == MW_SB) ? WriteDataM_i[7:0] :
         (MemWriteM_i == MW_SH) ? WriteDataM_i[8*(gi%2) +: 8] :
                                  WriteDataM_i[8*gi +: 8];
   end

   // Request and flag are forced low while reset is asserted.
   assign dmem.dmem_req_o  = rst_n && req;
   assign dmem.dmem_we_o   = is_store;
   assign dmem.dmem_addr_o = {ALUResultM_i[31:2], 2'b00};
   assign dmem.dmem_be_o   = be;
   assign misaligned_o     = rst_n && mis_flag;
   assign StallM_o         = busy && !complete;

   load_align u_load_align (
      .rdata_i  (dmem.dmem_rdata_i),
      .off_i    (off),
      .funct3_i (LoadFunct3M_i),
      .data_o   (load_data)
   );

   always_comb begin
      regwrite_w_d  = 1'b0;
      resultsrc_w_d = resultsrc_w_q;
      alu_w_d       = alu_w_q;
      rdata_w_d     = rdata_w_q;
      rd_w_d        = rd_w_q;
      pc4_w_d       = pc4_w_q;
      if (!StallM_o) begin
         regwrite_w_d  = RegWriteM_i && !mis_flag;
         resultsrc_w_d = ResultSrcM_i;
         alu_w_d       = ALUResultM_i;
         rd_w_d        = RdM_i;
         pc4_w_d       = PCPlus4M_i;
         if (state_q == ST_RESP) begin
            rdata_w_d = load_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         regwrite_w_q  <= 1'b0;
         resultsrc_w_q <= 2'b00;
         alu_w_q       <= 32'h0;
         rdata_w_q     <= 32'h0;
         rd_w_q        <= 5'h0;
         pc4_w_q       <= 32'h0;
      end else begin
         state_q       <= state_d;
         regwrite_w_q  <= regwrite_w_d;
         resultsrc_w_q <= resultsrc_w_d;
         alu_w_q       <= alu_w_d;
         rdata_w_q     <= rdata_w_d;
         rd_w_q        <= rd_w_d;
         pc4_w_q       <= pc4_w_d;
      end
   end

   assign RegWriteW_o  = regwrite_w_q;
   assign ResultSrcW_o = resultsrc_w_q;
   assign ALUResultW_o = alu_w_q;
   assign ReadDataW_o  = rdata_w_q;
   assign RdW_o        = rd_w_q;
   assign PCPlus4W_o   = pc4_w_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: driver issues M-stage ops and models memory,
// a monitor checks every W-register update against a scoreboard queue.
module tb_mem_stage_lsu;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        RegWriteM_i;
   logic [1:0]  ResultSrcM_i;
   logic [2:0]  MemWriteM_i;
   logic [2:0]  LoadFunct3M_i;
   logic [31:0] ALUResultM_i;
   logic [31:0] WriteDataM_i;
   logic [4:0]  RdM_i;
   logic [31:0] PCPlus4M_i;
   logic        StallM_o;
   logic        misaligned_o;
   logic        RegWriteW_o;
   logic [1:0]  ResultSrcW_o;
   logic [31:0] ALUResultW_o;
   logic [31:0] ReadDataW_o;
   logic [4:0]  RdW_o;
   logic [31:0] PCPlus4W_o;

   mem_stage_lsu_if dmem_bus();

   mem_stage_lsu dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .RegWriteM_i   (RegWriteM_i),
      .ResultSrcM_i  (ResultSrcM_i),
      .MemWriteM_i   (MemWriteM_i),
      .LoadFunct3M_i (LoadFunct3M_i),
      .ALUResultM_i  (ALUResultM_i),
      .WriteDataM_i  (WriteDataM_i),
      .RdM_i         (RdM_i),
      .PCPlus4M_i    (PCPlus4M_i),
      .dmem          (dmem_bus),
      .StallM_o      (StallM_o),
      .misaligned_o  (misaligned_o),
      .RegWriteW_o   (RegWriteW_o),
      .ResultSrcW_o  (ResultSrcW_o),
      .ALUResultW_o  (ALUResultW_o),
      .ReadDataW_o   (ReadDataW_o),
      .RdW_o         (RdW_o),
      .PCPlus4W_o    (PCPlus4W_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rw;
      logic [1:0]  rs;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] rdat;
      bit          chk_rd;
   } wexp_t;

   wexp_t exp_q[$];
   int    tests = 0;
   int    fails = 0;
   bit    issuing = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic set_nop();
      RegWriteM_i   = 1'b0;
      ResultSrcM_i  = 2'b00;
      MemWriteM_i   = 3'b000;
      LoadFunct3M_i = 3'b000;
      ALUResultM_i  = 32'h0;
      WriteDataM_i  = 32'h0;
      RdM_i         = 5'h0;
      PCPlus4M_i    = 32'h0;
      dmem_bus.dmem_ready_i  = 1'b0;
      dmem_bus.dmem_rvalid_i = 1'b0;
      dmem_bus.dmem_rdata_i  = 32'h0;
   endtask

   // Monitor: a cycle with the op present and no stall commits into W at the next edge.
   initial begin : monitor
      bit    pend;
      wexp_t e;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (pend) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL w_extra: got unexpected W update, required none");
            end else begin
               e = exp_q.pop_front();
               chk("w_regwrite",  {31'b0, RegWriteW_o}, {31'b0, e.rw});
               chk("w_resultsrc", {30'b0, ResultSrcW_o}, {30'b0, e.rs});
               chk("w_aluresult", ALUResultW_o, e.alu);
               chk("w_rd",        {27'b0, RdW_o}, {27'b0, e.rd});
               chk("w_pcplus4",   PCPlus4W_o, e.pc);
               if (e.chk_rd) chk("w_readdata", ReadDataW_o, e.rdat);
            end
         end
         pend = issuing && !StallM_o && rst_n;
      end
   end

   task automatic do_op(
      input string nm, input logic rw, input logic [1:0] rs, input logic [2:0] mw,
      input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
      input logic [4:0] rd, input logic [31:0] pc, input int rdy_wait,
      input logic [31:0] rdata, input logic exp_rw, input logic [31:0] exp_rd,
      input bit chk_rd, input int exp_req, input int exp_stall, input int exp_mis,
      input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      wexp_t e;
      int    cyc, n_req, n_stall, n_mis;
      bit    accepted, done;
      e.rw = exp_rw; e.rs = rs; e.alu = alu; e.rd = rd; e.pc = pc;
      e.rdat = exp_rd; e.chk_rd = chk_rd;
      exp_q.push_back(e);
      RegWriteM_i = rw; ResultSrcM_i = rs; MemWriteM_i = mw; LoadFunct3M_i = f3;
      ALUResultM_i = alu; WriteDataM_i = wd; RdM_i = rd; PCPlus4M_i = pc;
      issuing = 1'b1;
      cyc = 0; n_req = 0; n_stall = 0; n_mis = 0; accepted = 0; done = 0;
      while (!done && cyc < 20) begin
         dmem_bus.dmem_ready_i  = !accepted && (cyc >= rdy_wait);
         // rvalid is also raised spuriously when no response is due; it must be ignored.
         dmem_bus.dmem_rvalid_i = accepted || (cyc < rdy_wait) || (exp_req == 0);
         dmem_bus.dmem_rdata_i  = accepted ? rdata : 32'hDEAD_BEEF;
         @(negedge clk);
         if (dmem_bus.dmem_req_o) begin
            n_req++;
            chk({nm, "_addr"}, dmem_bus.dmem_addr_o, {alu[31:2], 2'b00});
            chk({nm, "_we"},   {31'b0, dmem_bus.dmem_we_o}, {31'b0, exp_we});
            chk({nm, "_be"},   {28'b0, dmem_bus.dmem_be_o}, {28'b0, exp_be});
            if (exp_we) chk({nm, "_wdata"}, dmem_bus.dmem_wdata_o, exp_wdata);
            if (dmem_bus.dmem_ready_i) accepted = 1;
         end
         if (StallM_o) n_stall++;
         if (misaligned_o) n_mis++;
         if (!StallM_o) done = 1;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no completion in %0d cycles, required completion", nm, cyc);
      end
      chk({nm, "_req_cycles"},   32'(n_req),   32'(exp_req));
      chk({nm, "_stall_cycles"}, 32'(n_stall), 32'(exp_stall));
      chk({nm, "_misaligned"},   32'(n_mis),   32'(exp_mis));
      $display("[TB] %s: req_cycles=%0d stall_cycles=%0d misaligned_cycles=%0d", nm, n_req, n_stall, n_mis);
      issuing = 1'b0;
      set_nop();
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      set_nop();
      #1 rst_n = 1'b0;
      // Present an aligned load during reset: request must stay gated off.
      RegWriteM_i = 1'b1; ResultSrcM_i = RES_LOAD; LoadFunct3M_i = LD_LW; ALUResultM_i = 32'h40;
      dmem_bus.dmem_ready_i = 1'b1; dmem_bus.dmem_rvalid_i = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_regwrite_w", {31'b0, RegWriteW_o}, 32'h0);
      chk("rst_aluresult_w", ALUResultW_o, 32'h0);
      chk("rst_readdata_w", ReadDataW_o, 32'h0);
      chk("rst_req", {31'b0, dmem_bus.dmem_req_o}, 32'h0);
      chk("rst_misaligned", {31'b0, misaligned_o}, 32'h0);
      $display("[TB] reset: W outputs and bus request checked");
      @(posedge clk);
      #1;
      set_nop();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      //    name            rw  rs     mw      f3      alu          wdata        rd     pc        wait rdata        exp_rw exp_rd       chk req stl mis we    be       exp_wdata
      do_op("alu_op",       1, 2'b00, 3'b000, 3'b000, 32'h1234,    32'h0,       5'd5,  32'h104,  0, 32'h0,        1, 32'h0,        0,  0,  0,  0,  0, 4'b1111, 32'h0);
      do_op("lb_1003",      1, 2'b01, 3'b000, 3'b000, 32'h1003,    32'h0,       5'd7,  32'h108,  0, 32'h80FF_FF12, 1, 32'hFFFF_FF80, 1, 1,  1,  0,  0, 4'b1111, 32'h0);
      do_op("sh_2002",      0, 2'b00, 3'b010, 3'b000, 32'h2002,    32'h0000_ABCD, 5'd0, 32'h10C, 3, 32'h0,        0, 32'h0,        0,  4,  3,  0,  1, 4'b1100, 32'hABCD_ABCD);
      do_op("lw_0006_mis",  1, 2'b01, 3'b000, 3'b010, 32'h0006,    32'h0,       5'd8,  32'h110,  0, 32'h0,        0, 32'h0,        0,  0,  0,  1,  0, 4'b1111, 32'h0);
      do_op("lhu_0002",     1, 2'b01, 3'b000, 3'b101, 32'h0002,    32'h0,       5'd9,  32'h114,  0, 32'h8001_0000, 1, 32'h0000_8001, 1, 1,  1,  0,  0, 4'b1111, 32'h0);
      do_op("sb_0101",      0, 2'b00, 3'b001, 3'b000, 32'h0101,    32'h1234_565A, 5'd0, 32'h118, 1, 32'h0,        0, 32'h0,        0,  2,  1,  0,  1, 4'b0010, 32'h5A5A_5A5A);
      do_op("sw_0200",      0, 2'b00, 3'b100, 3'b000, 32'h0200,    32'hCAFE_F00D, 5'd0, 32'h11C, 0, 32'h0,        0, 32'h0,        0,  1,  0,  0,  1, 4'b1111, 32'hCAFE_F00D);
      do_op("lh_0006",      1, 2'b01, 3'b000, 3'b001, 32'h0006,    32'h0,       5'd10, 32'h120,  0, 32'h8001_7FFF, 1, 32'hFFFF_8001, 1, 1,  1,  0,  0, 4'b1111, 32'h0);
      do_op("lbu_0001_w2",  1, 2'b01, 3'b000, 3'b100, 32'h0001,    32'h0,       5'd11, 32'h124,  2, 32'h0000_9C00, 1, 32'h0000_009C, 1, 3,  3,  0,  0, 4'b1111, 32'h0);
      do_op("sw_0202_mis",  0, 2'b00, 3'b100, 3'b000, 32'h0202,    32'h1122_3344, 5'd0, 32'h128, 0, 32'h0,        0, 32'h0,        0,  0,  0,  1,  0, 4'b1111, 32'h0);
      do_op("ld_st_both",   1, 2'b01, 3'b100, 3'b010, 32'h0300,    32'h55AA_55AA, 5'd12, 32'h12C, 0, 32'h0,       1, 32'h0,        0,  1,  0,  0,  1, 4'b1111, 32'h55AA_55AA);
      do_op("mw_bad_code",  1, 2'b00, 3'b011, 3'b000, 32'hBEEF,    32'h0,       5'd13, 32'h130,  0, 32'h0,        1, 32'h0,        0,  0,  0,  0,  0, 4'b1111, 32'h0);

      // Reset while a load waits in RESP; a late rvalid must not reach W.
      RegWriteM_i = 1'b1; ResultSrcM_i = RES_LOAD; LoadFunct3M_i = LD_LW;
      ALUResultM_i = 32'h40; RdM_i = 5'd9; PCPlus4M_i = 32'h300;
      dmem_bus.dmem_ready_i = 1'b1;
      @(negedge clk);
      chk("rresp_req_idle", {31'b0, dmem_bus.dmem_req_o}, 32'h1);
      @(posedge clk);
      #1;
      dmem_bus.dmem_ready_i = 1'b0;
      @(negedge clk);
      chk("rresp_req_resp", {31'b0, dmem_bus.dmem_req_o}, 32'h0);
      chk("rresp_stall", {31'b0, StallM_o}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rresp_alu_w", ALUResultW_o, 32'h0);
      chk("rresp_pc_w", PCPlus4W_o, 32'h0);
      chk("rresp_rd_w", {27'b0, RdW_o}, 32'h0);
      chk("rresp_req", {31'b0, dmem_bus.dmem_req_o}, 32'h0);
      set_nop();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      dmem_bus.dmem_rvalid_i = 1'b1;
      dmem_bus.dmem_rdata_i  = 32'h1234_5678;
      @(negedge clk);
      chk("late_rvalid_stall", {31'b0, StallM_o}, 32'h0);
      @(posedge clk);
      #1;
      chk("late_rvalid_rdata_w", ReadDataW_o, 32'h0);
      chk("late_rvalid_regwrite_w", {31'b0, RegWriteW_o}, 32'h0);
      $display("[TB] reset_in_resp: W cleared, late rvalid checked");
      set_nop();
      @(posedge clk);
      #1;
      do_op("sw_after_rst", 0, 2'b00, 3'b100, 3'b000, 32'h0400, 32'h0BAD_F00D, 5'd0, 32'h140, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0, 1, 4'b1111, 32'h0BAD_F00D);

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have one clock, clk; reset is rst_n, asynchronous, active-low.
REQ-002 SHALL provide ports (name direction width meaning):
- clk in 1: clock, rising edge.
- rst_n in 1: async active-low reset.
- RegWriteM_i in 1: M-stage register write.
- ResultSrcM_i in 2: 2'b01 = load result.
- MemWriteM_i in 3: 000 none, 001 SB, 010 SH, 100 SW; other codes = none.
- LoadFunct3M_i in 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ALUResultM_i in 32: byte address or ALU result.
- WriteDataM_i in 32: store data, low bits.
- RdM_i in 5: destination register.
- PCPlus4M_i in 32: PC+4.
- dmem_req_o out 1: request valid.
- dmem_we_o out 1: 1 = store.
- dmem_addr_o out 32: {ALUResultM_i[31:2],2'b00}.
- dmem_be_o out 4: byte-lane enables.
- dmem_wdata_o out 32: lane-replicated store data.
- dmem_ready_i in 1: request accepted this cycle.
- dmem_rvalid_i in 1: load data valid.
- dmem_rdata_i in 32: load word.
- StallM_o out 1: hold F/D/E/M stages.
- misaligned_o out 1: one-cycle misaligned-access flag.
- RegWriteW_o, ResultSrcW_o(2), ALUResultW_o(32), ReadDataW_o(32), RdW_o(5), PCPlus4W_o(32) out: W-stage register.

Function
REQ-003 SHALL treat ResultSrcM_i==2'b01 as load and MemWriteM_i in {001,010,100} as store; both = store; neither = pass-through.
REQ-004 FSM: IDLE, REQ, RESP; reset state IDLE.
- IDLE: memory op, aligned, !ready -> REQ; load with ready -> RESP.
- REQ: load with ready -> RESP; store with ready -> IDLE.
- RESP: rvalid -> IDLE.
REQ-005 dmem_req_o SHALL be high in IDLE (aligned memory op) and in REQ, low in RESP; addr/be/wdata/we SHALL remain stable while req is high and ready is low.
REQ-006 Store completes in the cycle req&&ready; load completes in the RESP cycle with rvalid.
REQ-007 StallM_o SHALL equal (aligned memory op) && !(completes this cycle), combinationally.
REQ-008 W register SHALL load all M fields on a rising edge when StallM_o==0; when StallM_o==1 it SHALL load a bubble (RegWriteW_o=0, others hold).
REQ-009 Byte enables: SB 4'b0001<<addr[1:0]; SH addr[1]?1100:0011; SW 1111; loads 1111.
REQ-010 wdata: SB {4{data[7:0]}}, SH {2{data[15:0]}}, SW data.
REQ-011 ReadDataW_o SHALL be the selected byte/half of dmem_rdata_i, sign-extended (LB/LH) or zero-extended (LBU/LHU), LW unchanged; captured at completion edge.
REQ-012 Misaligned = SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=0: no request, no stall, misaligned_o=1 that cycle, W captures the instruction with RegWriteW_o=0.
REQ-013 rvalid outside RESP SHALL be ignored.
REQ-014 Latency: pass-through 1 cycle; store 1 cycle plus ready-wait cycles; load 2 cycles minimum plus wait cycles.

Reset
REQ-015 On rst_n low: state IDLE, all W outputs 0, misaligned_o 0, dmem_req_o 0; any in-flight access is abandoned and its late rvalid ignored (REQ-013).

Structure
REQ-016 Package mem_pkg SHALL hold the FSM state enum, MemWrite codes, load funct3 codes, and the ResultSrc load code.
REQ-017 Sub-module load_align (combinational: rdata, addr[1:0], funct3 -> 32-bit extended result) SHALL be instantiated once.

Verification
REQ-018 LB at 0x1003, ready=1, rdata 0x80FF_FF12 one cycle after acceptance -> ReadDataW_o 0xFFFF_FF80, StallM_o high 1 cycle.
REQ-019 SH at 0x2002 with data 0x0000_ABCD, ready low 3 cycles -> be 1100, wdata 0xABCD_ABCD stable 4 cycles, StallM_o high 3 cycles.
REQ-020 LW at 0x0006 -> no dmem_req_o, misaligned_o=1 for one cycle, RegWriteW_o=0, no stall.
REQ-021 ALU op (RegWrite=1, Rd=5, result 0x1234) -> W fields next cycle, dmem_req_o never high.
REQ-022 rst_n low during RESP, then rvalid=1 -> state IDLE, rvalid ignored, W outputs 0.
REQ-023 LHU at 0x0002, rdata 0x8001_0000 -> ReadDataW_o 0x0000_8001.
